sobel_edge_engine: RTL and testbench

- Downstream stage of the median filter engine.
- After the median stage finishes writing the 128x128 filtered image into the result RAM, this block reads that image back in raster order and computes a 3x3 Sobel gradient magnitude per pixel.
- Writes the 8-bit edge image to a second RAM.
- Uses a sliding 3x3 window with zero padding outside the image, so each new column needs only 3 reads.

---
 rtl/sobel_edge_if.sv | 47 ++++
 rtl/sobel_edge_engine.sv | 273 +++++++++++++++++++++++++++
 tb/tb_sobel_edge_engine.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sobel_edge_if.sv
// sobel_edge_if: handshake and RAM-port bundle of the Sobel edge engine.
//
// Signals
//   start  host -> engine   one-cycle pulse, begin frame
//   busy   engine -> host   frame in progress
//   done   engine -> host   one-cycle pulse after the final edge-pixel write
//   raddr  engine -> RAM    read address into the filtered-image RAM
//   rdata  RAM -> engine    read data, valid one cycle after raddr
//   waddr  engine -> RAM    write address into the edge RAM
//   wdata  engine -> RAM    edge pixel
//   wen    engine -> RAM    write strobe, one cycle per pixel
//
// Modports
//   slave  : the engine side
//   master : the host / memory side that drives start and rdata
interface sobel_edge_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [13:0] raddr;
  logic [7:0]  rdata;
  logic [13:0] waddr;
  logic [7:0]  wdata;
  logic        wen;

  modport slave (
    input  start,
    input  rdata,
    output busy,
    output done,
    output raddr,
    output waddr,
    output wdata,
    output wen
  );

  modport master (
    output start,
    output rdata,
    input  busy,
    input  done,
    input  raddr,
    input  waddr,
    input  wdata,
    input  wen
  );
endinterface

// File: rtl/sobel_edge_engine.sv
// sobel_edge_engine: reads an IMG_W x IMG_W 8-bit image in raster order and
// writes the 3x3 Sobel gradient magnitude |Gx|+|Gy| (saturated to 255) of every
// pixel to a second RAM. A sliding 3x3 window with zero padding outside the
// image means each new column costs three reads.
//
// Per-pixel sequence: SHIFT, LOAD x3, CAP, CALC (6 cycles). The first pixel of
// each row loads two columns (LOAD x3, CAP twice) for 10 cycles. The write
// strobe is registered at the end of CALC, so it overlaps the next SHIFT.
//
// Ports
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    sobel_edge_if.slave: start/busy/done, raddr/rdata, waddr/wdata/wen
//
// Parameters
//   IMG_W   image width and height, power of two, IMG_W*IMG_W <= 16384
//   THRESH  binarisation threshold (only with SOBEL_THRESH_EN)
//
// Build option
//   SOBEL_THRESH_EN  defined: wdata = 255 when magnitude >= THRESH, else 0.
//                    undefined: wdata = min(magnitude, 255).
module sobel_edge_engine #(
  parameter int IMG_W  = 128,
  parameter int THRESH = 128
) (
  input  logic         clk,
  input  logic         reset,
  sobel_edge_if.slave  bus
);

  localparam int             CW      = $clog2(IMG_W);
  localparam logic [CW-1:0]  LAST    = CW'(IMG_W - 1);
  localparam logic [CW:0]    COL_END = (CW + 1)'(IMG_W);

  if (IMG_W < 4 || (IMG_W & (IMG_W - 1)) != 0 || 2 * CW > 14 ||
      THRESH < 0 || THRESH > 4095) begin : g_param_check
    $error("sobel_edge_engine: unsupported IMG_W or THRESH");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_LOAD,
    S_CAP,
    S_CALC,
    S_FIN
  } state_t;

  state_t        state;
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic [CW:0]   ld_col;     // image column being loaded (may be IMG_W = pad)
  logic [1:0]    ld_slot;    // window column receiving the loaded pixels
  logic [1:0]    ld_k;       // window row of the read in flight
  logic          pass2;      // row start: second column load done/underway
  logic          rd_oob;     // address on raddr lies outside the image
  logic          cap_vld;
  logic          cap_oob;
  logic [3:0]    cap_idx;
  logic [7:0]    win [0:8];  // p0..p8, row-major, win[4] is the centre

  logic          busy_r;
  logic          done_r;
  logic          wen_r;
  logic [13:0]   raddr_r;
  logic [13:0]   waddr_r;
  logic [7:0]    wdata_r;

  logic signed [10:0] gx;
  logic signed [10:0] gy;
  logic [11:0]        mag;
  logic [7:0]         edge_val;

  // Address of window row k (rows r-1, r, r+1) in column c; wraps to 14 bits
  // for the padding positions, whose data is discarded anyway.
  function automatic logic [13:0] rd_addr(input logic [CW-1:0] r,
                                          input logic [CW:0]   c,
                                          input logic [1:0]    k);
    logic [13:0] rr;
    rr = 14'(r) + 14'(k) - 14'd1;
    return (rr << CW) + 14'(c);
  endfunction

  function automatic logic is_oob(input logic [CW-1:0] r,
                                  input logic [CW:0]   c,
                                  input logic [1:0]    k);
    return (r == '0 && k == 2'd0) || (r == LAST && k == 2'd2) ||
           (c == COL_END);
  endfunction

  function automatic logic [3:0] slot_idx(input logic [1:0] k,
                                          input logic [1:0] s);
    return {2'b00, k} + {1'b0, k, 1'b0} + {2'b00, s};
  endfunction

  function automatic logic signed [10:0] px(input logic [7:0] v);
    return signed'({3'b000, v});
  endfunction

  function automatic logic [10:0] abs11(input logic signed [10:0] v);
    return v[10] ? 11'(-v) : 11'(v);
  endfunction

  function automatic logic [7:0] sat_u8(input logic [11:0] m);
    return (m > 12'd255) ? 8'hFF : m[7:0];
  endfunction

`ifdef SOBEL_THRESH_EN
  function automatic logic [7:0] thresh_u8(input logic [11:0] m);
    return (m >= 12'(THRESH)) ? 8'hFF : 8'h00;
  endfunction
`endif

  // Gradient of the current window; consumed in CALC.
  always_comb begin
    gx  = (px(win[2]) + (px(win[5]) <<< 1) + px(win[8])) -
          (px(win[0]) + (px(win[3]) <<< 1) + px(win[6]));
    gy  = (px(win[6]) + (px(win[7]) <<< 1) + px(win[8])) -
          (px(win[0]) + (px(win[1]) <<< 1) + px(win[2]));
    mag = {1'b0, abs11(gx)} + {1'b0, abs11(gy)};
`ifdef SOBEL_THRESH_EN
    edge_val = thresh_u8(mag);
`else
    edge_val = sat_u8(mag);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      row     <= '0;
      col     <= '0;
      ld_col  <= '0;
      ld_slot <= '0;
      ld_k    <= '0;
      pass2   <= 1'b0;
      rd_oob  <= 1'b0;
      cap_vld <= 1'b0;
      cap_oob <= 1'b0;
      cap_idx <= '0;
      win[0]  <= '0;
      win[1]  <= '0;
      win[2]  <= '0;
      win[3]  <= '0;
      win[4]  <= '0;
      win[5]  <= '0;
      win[6]  <= '0;
      win[7]  <= '0;
      win[8]  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      wen_r   <= 1'b0;
      raddr_r <= '0;
      waddr_r <= '0;
      wdata_r <= '0;
    end else begin
      cap_vld <= 1'b0;
      wen_r   <= 1'b0;
      done_r  <= 1'b0;

      // Read data of the previous LOAD cycle lands in its window slot.
      if (cap_vld) begin
        win[cap_idx] <= cap_oob ? 8'h00 : bus.rdata;
      end

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            busy_r <= 1'b1;
            row    <= '0;
            col    <= '0;
            state  <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (col == '0) begin
            // Row start: left column is padding, load column 0 into the centre.
            win[0]  <= '0;
            win[1]  <= '0;
            win[2]  <= '0;
            win[3]  <= '0;
            win[4]  <= '0;
            win[5]  <= '0;
            win[6]  <= '0;
            win[7]  <= '0;
            win[8]  <= '0;
            ld_col  <= '0;
            ld_slot <= 2'd1;
            raddr_r <= rd_addr(row, '0, 2'd0);
            rd_oob  <= is_oob(row, '0, 2'd0);
          end else begin
            win[0]  <= win[1];
            win[1]  <= win[2];
            win[2]  <= '0;
            win[3]  <= win[4];
            win[4]  <= win[5];
            win[5]  <= '0;
            win[6]  <= win[7];
            win[7]  <= win[8];
            win[8]  <= '0;
            ld_col  <= {1'b0, col} + {{CW{1'b0}}, 1'b1};
            ld_slot <= 2'd2;
            raddr_r <= rd_addr(row, {1'b0, col} + {{CW{1'b0}}, 1'b1}, 2'd0);
            rd_oob  <= is_oob(row, {1'b0, col} + {{CW{1'b0}}, 1'b1}, 2'd0);
          end
          ld_k  <= 2'd0;
          pass2 <= 1'b0;
          state <= S_LOAD;
        end

        S_LOAD: begin
          cap_vld <= 1'b1;
          cap_oob <= rd_oob;
          cap_idx <= slot_idx(ld_k, ld_slot);
          if (ld_k == 2'd2) begin
            state <= S_CAP;
          end else begin
            ld_k    <= ld_k + 2'd1;
            raddr_r <= rd_addr(row, ld_col, ld_k + 2'd1);
            rd_oob  <= is_oob(row, ld_col, ld_k + 2'd1);
          end
        end

        S_CAP: begin
          if (col == '0 && !pass2) begin
            // Second load of a row start: column 1 into the right slot.
            pass2   <= 1'b1;
            ld_col  <= {{CW{1'b0}}, 1'b1};
            ld_slot <= 2'd2;
            ld_k    <= 2'd0;
            raddr_r <= rd_addr(row, {{CW{1'b0}}, 1'b1}, 2'd0);
            rd_oob  <= is_oob(row, {{CW{1'b0}}, 1'b1}, 2'd0);
            state   <= S_LOAD;
          end else begin
            state <= S_CALC;
          end
        end

        S_CALC: begin
          wen_r   <= 1'b1;
          wdata_r <= edge_val;
          waddr_r <= 14'({row, col});
          if (col == LAST) begin
            col <= '0;
            row <= row + CW'(1);
          end else begin
            col <= col + CW'(1);
          end
          state <= (row == LAST && col == LAST) ? S_FIN : S_SHIFT;
        end

        S_FIN: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
          row    <= '0;
          col    <= '0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.wen   = wen_r;
  assign bus.raddr = raddr_r;
  assign bus.waddr = waddr_r;
  assign bus.wdata = wdata_r;

endmodule

// File: tb/tb_sobel_edge_engine.sv
// Directed testbench for sobel_edge_engine on a 16x16 image. A one-cycle
// latency RAM model feeds the engine; written pixels are collected and
// compared against hand-computed values and a reference Sobel model.
module tb_sobel_edge_engine;

  localparam int W  = 16;
  localparam int N  = W * W;
  localparam int AW = 8;

`ifdef SOBEL_THRESH_EN
  localparam int E200 = 255;
  localparam int E20  = 0;
`else
  localparam int E200 = 200;
  localparam int E20  = 20;
`endif

  logic clk = 1'b0;
  logic reset;

  sobel_edge_if bus ();

  sobel_edge_engine #(.IMG_W(W), .THRESH(128)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] img     [N];
  logic [7:0] out_img [N];
  int         wcnt    [N];

  int n_checks = 0;
  int n_err    = 0;
  int wen_total, done_cnt, done_long, busy_at_done;
  int last_waddr;
  int frame_len;
  logic done_prev = 1'b0;

  // Filtered-image RAM: data valid one cycle after the address.
  always @(posedge clk) bus.rdata <= img[bus.raddr[AW-1:0]];

  always @(negedge clk) begin
    if (bus.wen === 1'b1) begin
      out_img[bus.waddr[AW-1:0]] = bus.wdata;
      wcnt[bus.waddr[AW-1:0]]++;
      wen_total++;
      last_waddr = int'(bus.waddr);
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (bus.busy !== 1'b0) busy_at_done++;
      if (done_prev) done_long++;
    end
    done_prev = (bus.done === 1'b1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pix(input int r, input int c);
    if (r < 0 || r >= W || c < 0 || c >= W) return 0;
    return int'(img[r * W + c]);
  endfunction

  function automatic int gold(input int r, input int c);
    int gxv, gyv, m;
    gxv = (pix(r-1, c+1) + 2 * pix(r, c+1) + pix(r+1, c+1)) -
          (pix(r-1, c-1) + 2 * pix(r, c-1) + pix(r+1, c-1));
    gyv = (pix(r+1, c-1) + 2 * pix(r+1, c) + pix(r+1, c+1)) -
          (pix(r-1, c-1) + 2 * pix(r-1, c) + pix(r-1, c+1));
    m = (gxv < 0 ? -gxv : gxv) + (gyv < 0 ? -gyv : gyv);
`ifdef SOBEL_THRESH_EN
    return (m >= 128) ? 255 : 0;
`else
    return (m > 255) ? 255 : m;
`endif
  endfunction

  function automatic int outp(input int r, input int c);
    return int'(out_img[r * W + c]);
  endfunction

  task automatic clear_stats();
    for (int i = 0; i < N; i++) begin
      wcnt[i]    = 0;
      out_img[i] = 8'h00;
    end
    wen_total    = 0;
    done_cnt     = 0;
    done_long    = 0;
    busy_at_done = 0;
    last_waddr   = -1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  // Run one frame; an optional second start pulse arrives second_at cycles in.
  task automatic run_frame(input int second_at);
    int cyc;
    clear_stats();
    pulse_start();
    cyc = 0;
    while (done_cnt == 0 && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      bus.start = (cyc == second_at);
    end
    bus.start = 1'b0;
    frame_len = cyc;
    if (done_cnt == 0) check("frame_timeout", 0, 1);
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic frame_checks(input string tag);
    int mism, badw;
    mism = 0;
    badw = 0;
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++)
        if (outp(r, c) != gold(r, c)) mism++;
    for (int i = 0; i < N; i++) if (wcnt[i] != 1) badw++;
    check({tag, "_golden_mismatches"}, mism, 0);
    check({tag, "_addr_not_once"}, badw, 0);
    check({tag, "_wen_count"}, wen_total, N);
    check({tag, "_final_waddr"}, last_waddr, N - 1);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_done_wide"}, done_long, 0);
    check({tag, "_busy_in_done"}, busy_at_done, 0);
    check({tag, "_frame_len_in_range"},
          int'(frame_len >= 1598 && frame_len <= 1606), 1);
  endtask

  initial begin
    reset     = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < N; i++) img[i] = 8'd100;
    clear_stats();

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  int'(bus.busy),  0);
    check("rst_done",  int'(bus.done),  0);
    check("rst_wen",   int'(bus.wen),   0);
    check("rst_raddr", int'(bus.raddr), 0);
    check("rst_waddr", int'(bus.waddr), 0);
    check("rst_wdata", int'(bus.wdata), 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Uniform image of 100.
    run_frame(0);
    frame_checks("uni");
    check("uni_0_0",   outp(0, 0),   255);
    check("uni_8_8",   outp(8, 8),   0);
    check("uni_15_15", outp(15, 15), 255);
    check("uni_0_8",   outp(0, 8),   255);

    // Vertical step at column 8, with a stray start mid-frame.
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++)
        img[r * W + c] = (c < 8) ? 8'd0 : 8'd50;
    run_frame(500);
    frame_checks("step");
    check("step_3_6", outp(3, 6), 0);
    check("step_3_7", outp(3, 7), E200);
    check("step_3_8", outp(3, 8), E200);
    check("step_3_9", outp(3, 9), 0);

    // Single impulse of 10 at (5,5).
    for (int i = 0; i < N; i++) img[i] = 8'd0;
    img[5 * W + 5] = 8'd10;
    run_frame(0);
    frame_checks("imp");
    check("imp_5_4", outp(5, 4), E20);
    check("imp_4_5", outp(4, 5), E20);
    check("imp_4_4", outp(4, 4), E20);
    check("imp_5_5", outp(5, 5), 0);
    check("imp_7_7", outp(7, 7), 0);

    // Reset mid-frame, then a full frame of pseudo-random pixels.
    for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
    pulse_start();
    repeat (600) @(posedge clk);
    #1;
    check("pre_rst_busy", int'(bus.busy), 1);
    reset = 1'b0;
    #1;
    check("async_rst_busy",  int'(bus.busy),  0);
    check("async_rst_wen",   int'(bus.wen),   0);
    check("async_rst_done",  int'(bus.done),  0);
    check("async_rst_raddr", int'(bus.raddr), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    run_frame(0);
    frame_checks("rnd");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
